// File: rtl/caravan_wb_pkg.sv
// Shared types and LA bit positions for the LA-driven Wishbone initiator.
package caravan_wb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wb_state_e;

  // Command fields on la_data_in
  localparam int ADR_LSB   = 0;
  localparam int WDATA_LSB = 32;
  localparam int SEL_LSB   = 64;
  localparam int WE_BIT    = 68;
  localparam int GO_BIT    = 69;

  // Status fields on la_data_out
  localparam int RDATA_LSB = 0;
  localparam int BUSY_BIT  = 32;
  localparam int DONE_BIT  = 33;
  localparam int ERR_BIT   = 34;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
  } wb_cmd_t;

  function automatic wb_cmd_t la_cmd(input logic [127:0] la);
    wb_cmd_t c;
    c.adr   = la[ADR_LSB   +: 32];
    c.wdata = la[WDATA_LSB +: 32];
    c.sel   = la[SEL_LSB   +: 4];
    c.we    = la[WE_BIT];
    return c;
  endfunction

endpackage

// File: rtl/la_wb_timeout.sv
// REQ-phase watchdog: counts cycles while enabled, flags the last allowed cycle.
module la_wb_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/la_wb_initiator.sv
// Single-beat Wishbone initiator commanded from LA lines via a go toggle.
// Define WB_INIT_TIMEOUT_EN to build the REQ timeout/abort path.
module la_wb_initiator
  import caravan_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("la_wb_initiator: TIMEOUT_CYCLES out of range for CNT_W");
  end

  wb_state_e   state_q, state_d;
  logic        go_q, go_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  wb_cmd_t cmd;
  logic    go_in;
  logic    accept;
  logic    timeout;

  assign cmd    = la_cmd(la_data_in);
  assign go_in  = la_data_in[GO_BIT];
  assign accept = (state_q == IDLE) && (go_in != go_q) && !la_oenb[GO_BIT];

`ifdef WB_INIT_TIMEOUT_EN
  la_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr_i   (accept),
    .en_i    (state_q == REQ),
    .expire_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    go_d    = go_in;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          cyc_d   = 1'b1;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          adr_d   = cmd.adr;
          dat_d   = cmd.wdata;
          sel_d   = cmd.sel;
          we_d    = cmd.we;
        end
      end
      REQ: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (wbm_ack_i) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = ~done_q;
          if (!we_q) rdata_d = wbm_dat_i;
        end else if (timeout) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          done_d  = ~done_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

  always_comb begin
    la_data_out                     = '0;
    la_data_out[RDATA_LSB +: 32]    = rdata_q;
    la_data_out[BUSY_BIT]           = busy_q;
    la_data_out[DONE_BIT]           = done_q;
    la_data_out[ERR_BIT]            = err_q;
  end

  logic unused_la;
  assign unused_la = ^{la_data_in[127:70], la_oenb[127:70], la_oenb[68:0]};

endmodule

// File: tb/tb_la_wb_initiator.sv
// Scoreboard bench for la_wb_initiator: stimulus queues expectations, monitor checks on done/cyc.
module tb_la_wb_initiator;

  localparam int TMO = 8;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic [127:0] la_data_in = '0;
  logic [127:0] la_oenb = '0;
  logic [127:0] la_data_out;
  logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o, wbm_dat_o;
  logic [31:0]  wbm_dat_i = '0;
  logic         wbm_ack_i = 1'b0;

  la_wb_initiator #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .la_data_in (la_data_in),
    .la_oenb    (la_oenb),
    .la_data_out(la_data_out),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] rdata;
    logic        err;
    int          cyc_len;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_rdata = '0;
  int          slave_wait = -1;
  logic [31:0] slave_data = '0;
  logic        force_ack = 1'b0;
  int          cyc_starts = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Slave: acks after slave_wait extra cycles of cyc (never if negative); force_ack acks unconditionally.
  initial begin
    int hi;
    hi = 0;
    forever begin
      @(posedge wb_clk_i);
      #1;
      if (wbm_cyc_o) hi++;
      else hi = 0;
      wbm_ack_i = force_ack || (wbm_cyc_o && slave_wait >= 0 && hi == slave_wait + 1);
      wbm_dat_i = slave_data;
    end
  end

  // Monitor: field checks during cyc, full response check on each done toggle.
  initial begin
    int   run;
    logic pd, pc;
    exp_t e;
    run = 0; pd = 1'b0; pc = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        run = 0; pd = 1'b0; pc = 1'b0;
        continue;
      end
      check("stb_eq_cyc", wbm_stb_o, wbm_cyc_o);
      if (wbm_cyc_o) begin
        if (!pc) cyc_starts++;
        run++;
        if (exp_q.size() == 0) check("cyc_no_cmd", wbm_cyc_o, 0);
        else begin
          check("adr", wbm_adr_o, exp_q[0].adr);
          check("wdata", wbm_dat_o, exp_q[0].wdata);
          check("sel", wbm_sel_o, exp_q[0].sel);
          check("we", wbm_we_o, exp_q[0].we);
          check("busy_in_req", la_data_out[32], 1);
        end
      end
      if (la_data_out[33] != pd) begin
        if (exp_q.size() == 0) check("done_no_cmd", la_data_out[33], pd);
        else begin
          e = exp_q.pop_front();
          check("rdata", la_data_out[31:0], e.rdata);
          check("err", la_data_out[34], e.err);
          check("busy_done", la_data_out[32], 0);
          check("cyc_len", run, e.cyc_len);
          check("cyc_low_done", wbm_cyc_o, 0);
          check("la_hi_zero", la_data_out[127:35], 0);
        end
        run = 0;
      end
      pd = la_data_out[33];
      pc = wbm_cyc_o;
    end
  end

  // Issue a command; wt < 0 means the slave never acks (timeout).
  task automatic issue(input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel,
                       input logic we, input int wt, input logic [31:0] sdata);
    exp_t e;
    e.adr = adr; e.wdata = wd; e.sel = sel; e.we = we;
    if (wt < 0) begin
      e.err = 1'b1; e.cyc_len = TMO;
    end else begin
      e.err = 1'b0; e.cyc_len = wt + 1;
      if (!we) model_rdata = sdata;
    end
    e.rdata = model_rdata;
    exp_q.push_back(e);
    slave_wait = wt;
    slave_data = sdata;
    la_data_in[31:0]  = adr;
    la_data_in[63:32] = wd;
    la_data_in[67:64] = sel;
    la_data_in[68]    = we;
    la_data_in[69]    = ~la_data_in[69];
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge wb_clk_i);
      #2;
      i++;
    end
    check("done_within_budget", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge wb_clk_i);
      #2;
    end
  endtask

  initial begin
    int   starts0;
    logic done0;
    idle(2);
    check("rst_la_out", la_data_out, 0);
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_bus", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, 0);
    wb_rst_i = 1'b0;
    idle(1);

    // Write with 2 wait states, then a zero-wait read issued back-to-back
    issue(32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 2, 32'hBAD0_0000);
    wait_done(20);
    issue(32'h3000_0000, 32'h0, 4'hF, 1'b0, 0, 32'h1234_5678);
    wait_done(20);
    issue(32'h3000_0010, 32'h0, 4'h3, 1'b0, 1, 32'hCAFE_F00D);
    wait_done(20);

    // Toggle while busy is dropped
    starts0 = cyc_starts;
    issue(32'h3000_0020, 32'h0, 4'hF, 1'b0, 4, 32'hA5A5_0001);
    idle(2);
    la_data_in[69] = ~la_data_in[69];
    wait_done(20);
    idle(6);
    check("busy_toggle_dropped", cyc_starts, starts0 + 1);

    // Toggle with la_oenb[69]=1 is not accepted
    starts0 = cyc_starts;
    la_oenb[69] = 1'b1;
    la_data_in[69] = ~la_data_in[69];
    idle(4);
    la_oenb[69] = 1'b0;
    idle(3);
    check("oenb_blocks_go", cyc_starts, starts0);

    // Ack while idle changes nothing
    starts0 = cyc_starts;
    done0 = la_data_out[33];
    force_ack = 1'b1;
    idle(2);
    force_ack = 1'b0;
    idle(2);
    check("ack_idle_cyc", cyc_starts, starts0);
    check("ack_idle_done", la_data_out[33], done0);

`ifdef WB_INIT_TIMEOUT_EN
    // Timeout, then next command clears err, then ack on the last allowed cycle
    issue(32'h3000_0030, 32'h0, 4'hF, 1'b0, -1, 32'h0);
    wait_done(40);
    issue(32'h3000_0034, 32'h0, 4'hF, 1'b0, 0, 32'h0BAD_F00D);
    wait_done(20);
    issue(32'h3000_0038, 32'h0, 4'hF, 1'b0, TMO - 1, 32'h7777_8888);
    wait_done(40);
`endif

    // Reset during REQ, then a late ack
    issue(32'h3000_0040, 32'h1111_2222, 4'hF, 1'b1, -1, 32'h0);
    idle(3);
    check("req_active_before_rst", wbm_cyc_o, 1);
    wb_rst_i = 1'b1;
    la_data_in[69] = 1'b0;
    exp_q.delete();
    model_rdata = '0;
    idle(1);
    check("rst_mid_la_out", la_data_out, 0);
    check("rst_mid_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, 0);
    wb_rst_i = 1'b0;
    force_ack = 1'b1;
    idle(1);
    force_ack = 1'b0;
    idle(1);
    check("late_ack_cyc", wbm_cyc_o, 0);
    check("late_ack_la_out", la_data_out, 0);
    issue(32'h3000_0044, 32'h0, 4'hC, 1'b0, 1, 32'h5555_AAAA);
    wait_done(20);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/la_wb_initiator.md
# la_wb_initiator

Wishbone initiator in the user area, driven from the management SoC's logic-analyzer bank. Management firmware writes an address, data, byte select and direction onto LA lines, then toggles a go bit. The block runs one classic single-beat Wishbone cycle on a user-side bus toward the user project's slave port, and returns read data and status on LA outputs. It is the initiator end of the Wishbone interface the user project already exposes as a slave. Firmware can exercise user slaves without routing through the management Wishbone.

## Interface

- TIMEOUT_CYCLES, 255: cycles in REQ without ack before abort (1..65535)
- CNT_W, 16: timeout counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, synchronous, active-high
- la_data_in  in  128  command: [31:0] adr, [63:32] wdata, [67:64] sel, [68] we, [69] go (toggle), [127:70] unused
- la_oenb  in  128  go is honoured only while la_oenb[69]=0
- la_data_out  out  128  status: [31:0] rdata, [32] busy, [33] done (toggle), [34] err, [127:35] = 0
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe; always equal to wbm_cyc_o
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte select
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  slave acknowledge

## Operation

- **Reset values:** all outputs 0; state IDLE; go_q 0; counter 0.
- **Accept:** go_q registers la_data_in[69] every cycle.
  - A command is accepted in IDLE when la_data_in[69] != go_q and la_oenb[69] = 0.
  - On accept, adr/wdata/sel/we are latched into the wbm_* output registers.
- **States:**
  - IDLE: accept -> REQ. cyc/stb=1, busy=1, err cleared, counter cleared.
  - REQ, wbm_ack_i=1 -> IDLE. cyc/stb/we=0. If not we, rdata <= wbm_dat_i. done toggles; busy=0.
  - REQ, counter = TIMEOUT_CYCLES-1 with no ack -> IDLE. cyc/stb/we=0, err=1, done toggles, rdata unchanged. (Timeout build only; see Configuration.)
  - REQ otherwise: stay; counter increments.
- **Toggle while busy:** ignored. go_q still tracks the input, so the toggle is dropped, not queued.
- **Ack in IDLE:** ignored.
- **Ack and timeout in the same cycle:** ack wins; err stays 0.
- **Hold during REQ:** wbm_adr_o/dat_o/sel_o/we_o are stable for the whole of REQ.
- **Reset mid-REQ:** cyc/stb drop at that edge; a late ack is ignored.

## Timing

- Accept sampled at edge N -> cyc/stb high from N+1.
- Ack sampled at edge M -> cyc/stb low, rdata valid and done toggled from M+1.
- Zero-wait slave: cyc high exactly 1 cycle; minimum command-to-done is 2 cycles.
- Back-to-back: a new go toggle can be accepted in the first IDLE cycle after done.
- Timeout: cyc high exactly TIMEOUT_CYCLES cycles.

## Configuration

- **WB_INIT_TIMEOUT_EN defined:** counter and abort path present; err reflects timeouts.
- **WB_INIT_TIMEOUT_EN undefined:**
  - No counter; REQ waits for ack indefinitely.
  - err is tied 0; TIMEOUT_CYCLES and CNT_W are unused.

## Structure

- **Package caravan_wb_pkg:** state enum (IDLE, REQ) and LA bit-index constants (ADR_LSB, WDATA_LSB, SEL_LSB, WE_BIT, GO_BIT, RDATA_LSB, BUSY_BIT, DONE_BIT, ERR_BIT).
- **Sub-module la_wb_timeout:** the counter with clear/enable inputs and an expire output. Instantiated only under WB_INIT_TIMEOUT_EN.

## Test plan

- **Write:** adr=0x3000_0004, wdata=0xDEAD_BEEF, sel=0xF, we=1, toggle go; slave acks after 2 cycles -> cyc high 3 cycles with stable fields; done toggles; busy 0; err 0.
- **Read:** adr=0x3000_0000, we=0; slave returns 0x1234_5678 with zero wait -> cyc high 1 cycle; rdata=0x1234_5678 at M+1.
- **Timeout:** TIMEOUT_CYCLES=8, no ack -> cyc high exactly 8 cycles; err=1; rdata unchanged. The next command clears err.
- **Ignored go:**
  - Toggle go while busy -> no second cycle after done.
  - Toggle with la_oenb[69]=1 -> no accept.
- **Reset mid-REQ:** assert wb_rst_i for 1 cycle during REQ, then ack -> all outputs 0 next cycle; ack ignored; next go works normally.
- **Ack/timeout collision:** ack on cycle TIMEOUT_CYCLES-1 -> err=0; rdata captured.
